data_memory_v2: RTL and testbench
=================================

DATA_MEMORY_V2 -- requirements
Module: data_memory_v2

Interface
REQ-001 Parameter NB_DEPTH, default 10: byte-address width; memory holds 2^(NB_DEPTH-2) words.
REQ-002 Parameter NB_COL, default 4: byte lanes per word.
REQ-003 Parameter COL_WIDTH, default 8: bits per lane; word width = NB_COL*COL_WIDTH (32).
REQ-004 i_clk  input  1  single clock; all writes on its rising edge.
REQ-005 i_rst  input  1  reset, asynchronous, active-low.
REQ-006 i_addr  input  NB_DEPTH  byte address; word index = i_addr[NB_DEPTH-1:2].
REQ-007 i_data  input  32  write data.
REQ-008 i_write_enable  input  2  write size: 00 disable, 01 byte, 10 halfword, 11 word.
REQ-009 i_read_enable  input  2  read size: 00 disable, 01 byte, 10 halfword, 11 word.
REQ-010 i_addr_debug  input  NB_DEPTH-2  debug word index.
REQ-011 i_debug_enb  input  1  1 = normal operation; 0 = debug access mode.
REQ-012 o_data  output  32  read data.
REQ-013 o_data_debug  output  32  debug read data.

Function
REQ-014 Storage: 2^(NB_DEPTH-2) x 32-bit words, byte-lane writable (NB_COL lanes of COL_WIDTH).
REQ-015 i_addr[1:0] ignored; no misalignment fault; sub-word accesses always use the low lanes of the addressed word.
REQ-016 Write on rising i_clk when i_debug_enb=1 and i_write_enable!=00: byte -> lane 0 = i_data[7:0]; halfword -> lanes 1:0 = i_data[15:0]; word -> all lanes = i_data; unwritten lanes keep their value.
REQ-017 i_debug_enb=0 suppresses all writes; stored data is frozen.
REQ-018 o_data combinational from mem[i_addr[NB_DEPTH-1:2]]: word -> full word; halfword -> {16'h0, word[15:0]}; byte -> {24'h0, word[7:0]}; disable -> 32'h0.
REQ-019 Read reflects a write in the same cycle only after the write edge (read-after-write: new data visible from that edge on, no bypass before it).
REQ-020 o_data_debug = mem[i_addr_debug] full word, combinational, valid in any mode, independent of i_read_enable.
REQ-021 Simultaneous read and write to the same word: o_data shows old data before the edge, new data after.
REQ-022 Address wrap: none needed; every i_addr value maps to a valid word.

Reset
REQ-023 i_rst=0 asynchronously clears every memory word to 0; writes are ignored while i_rst=0.
REQ-024 During reset o_data = 0 and o_data_debug = 0 (memory content is 0); normal operation resumes on the first rising edge after i_rst returns to 1.
REQ-025 Reset asserted mid-write: the write is discarded; the word reads 0.

Verification
REQ-026 i_addr=1013, i_data=32'h77777777, write=11, read=11, edge -> o_data=32'h77777777.
REQ-027 Then write=00, read=10 -> o_data=32'h00007777; read=01 -> o_data=32'h00000077; read=00 -> 32'h0.
REQ-028 i_data=32'hFFFF5555, write=10, read=11, edge -> o_data=32'h77775555; then i_data=32'hFFFFFF33, write=01, edge -> o_data=32'h77775533.
REQ-029 i_debug_enb=0, i_addr_debug=253 -> o_data_debug=32'h77775533; write=11 with i_data=0 and edge -> contents unchanged.
REQ-030 Pulse i_rst=0 between clock edges -> o_data and o_data_debug go 0 immediately; addr 1013 word reads 0 after release.

Source files
------------

// File: rtl/data_memory_v2_if.sv
// Bus bundle for data_memory_v2: normal byte-addressed port plus a word-indexed debug read port.
interface data_memory_v2_if #(
  parameter int unsigned NB_DEPTH   = 10,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [NB_DEPTH-1:0]   i_addr;
  logic [DATA_WIDTH-1:0] i_data;
  logic [1:0]            i_write_enable;
  logic [1:0]            i_read_enable;
  logic [NB_DEPTH-3:0]   i_addr_debug;
  logic                  i_debug_enb;
  logic [DATA_WIDTH-1:0] o_data;
  logic [DATA_WIDTH-1:0] o_data_debug;

  modport master (
    output i_addr, i_data, i_write_enable, i_read_enable, i_addr_debug, i_debug_enb,
    input  o_data, o_data_debug
  );

  modport slave (
    input  i_addr, i_data, i_write_enable, i_read_enable, i_addr_debug, i_debug_enb,
    output o_data, o_data_debug
  );
endinterface

// File: rtl/data_memory_v2.sv
// Byte-lane writable word memory with sized reads, a debug read port and async clear.
module data_memory_v2 #(
  parameter int unsigned NB_DEPTH  = 10,
  parameter int unsigned NB_COL    = 4,
  parameter int unsigned COL_WIDTH = 8
) (
  input logic              i_clk,
  input logic              i_rst,
  data_memory_v2_if.slave  bus
);
  localparam int unsigned DataWidth = NB_COL * COL_WIDTH;
  localparam int unsigned NbWords   = 1 << (NB_DEPTH - 2);

  logic [DataWidth-1:0] mem_q [NbWords];
  logic [DataWidth-1:0] mem_d [NbWords];
  logic [NB_DEPTH-3:0]  word_idx;
  logic [DataWidth-1:0] rd_word;
  logic [NB_COL-1:0]    lane_we;
  int unsigned          wr_bits;
  logic                 unused_addr_bits;

  assign word_idx         = bus.i_addr[NB_DEPTH-1:2];
  // Sub-word accesses always land on the low lanes, so the byte offset carries no information.
  assign unused_addr_bits = ^bus.i_addr[1:0];

  always_comb begin
    wr_bits = 0;
    unique case (bus.i_write_enable)
      2'b01:   wr_bits = 8;
      2'b10:   wr_bits = 16;
      2'b11:   wr_bits = DataWidth;
      default: wr_bits = 0;
    endcase
    lane_we = '0;
    for (int unsigned l = 0; l < NB_COL; l++) begin
      lane_we[l] = bus.i_debug_enb && (l * COL_WIDTH < wr_bits);
    end
  end

  always_comb begin
    mem_d = mem_q;
    for (int unsigned l = 0; l < NB_COL; l++) begin
      if (lane_we[l]) begin
        mem_d[word_idx][l*COL_WIDTH +: COL_WIDTH] = bus.i_data[l*COL_WIDTH +: COL_WIDTH];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < int'(NbWords); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_word = mem_q[word_idx];

  always_comb begin
    bus.o_data = '0;
    unique case (bus.i_read_enable)
      2'b01:   bus.o_data = DataWidth'(rd_word[7:0]);
      2'b10:   bus.o_data = DataWidth'(rd_word[15:0]);
      2'b11:   bus.o_data = rd_word;
      default: bus.o_data = '0;
    endcase
  end

  assign bus.o_data_debug = mem_q[bus.i_addr_debug];
endmodule

// File: tb/tb_data_memory_v2.sv
// Directed scoreboard bench for data_memory_v2.
module tb_data_memory_v2;
  logic clk;
  logic rst;

  data_memory_v2_if bus ();

  data_memory_v2 dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
    bit          dbg;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [256];

  task automatic push(input string tag, input logic [31:0] exp, input bit dbg);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    e.dbg = dbg;
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t        e;
    logic [31:0] obs;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed no entry, expected one");
    end else begin
      e   = sb.pop_front();
      obs = e.dbg ? bus.o_data_debug : bus.o_data;
      assert (obs === e.exp)
      else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] exp, input bit dbg);
    push(tag, exp, dbg);
    #1;
    check_pop();
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst                = 1'b0;
    bus.i_addr         = '0;
    bus.i_data         = '0;
    bus.i_write_enable = 2'b00;
    bus.i_read_enable  = 2'b11;
    bus.i_addr_debug   = '0;
    bus.i_debug_enb    = 1'b1;

    chk("reset_o_data", 32'h0, 1'b0);
    chk("reset_o_data_debug", 32'h0, 1'b1);
    @(negedge clk);
    rst = 1'b1;

    // Word write; old value visible before the edge, new value after.
    bus.i_addr         = 10'd1013;
    bus.i_data         = 32'h7777_7777;
    bus.i_write_enable = 2'b11;
    bus.i_read_enable  = 2'b11;
    chk("raw_before_edge", 32'h0, 1'b0);
    edge_step();
    chk("word_write", 32'h7777_7777, 1'b0);

    @(negedge clk);
    bus.i_write_enable = 2'b00;
    bus.i_read_enable  = 2'b10;
    chk("read_half", 32'h0000_7777, 1'b0);
    bus.i_read_enable = 2'b01;
    chk("read_byte", 32'h0000_0077, 1'b0);
    bus.i_read_enable = 2'b00;
    chk("read_disable", 32'h0, 1'b0);

    bus.i_data         = 32'hFFFF_5555;
    bus.i_write_enable = 2'b10;
    bus.i_read_enable  = 2'b11;
    edge_step();
    chk("half_write", 32'h7777_5555, 1'b0);
    @(negedge clk);
    bus.i_data         = 32'hFFFF_FF33;
    bus.i_write_enable = 2'b01;
    edge_step();
    chk("byte_write", 32'h7777_5533, 1'b0);

    // Debug mode: writes frozen, debug port still reads.
    @(negedge clk);
    bus.i_debug_enb    = 1'b0;
    bus.i_addr_debug   = 8'd253;
    bus.i_data         = 32'h0;
    bus.i_write_enable = 2'b11;
    chk("debug_read", 32'h7777_5533, 1'b1);
    edge_step();
    chk("frozen_o_data", 32'h7777_5533, 1'b0);
    chk("frozen_debug", 32'h7777_5533, 1'b1);

    @(negedge clk);
    bus.i_write_enable = 2'b00;
    bus.i_addr         = 10'd1012;
    chk("byte_offset_ignored", 32'h7777_5533, 1'b0);

    // Word writes across several indices, checked against a simple model.
    bus.i_debug_enb = 1'b1;
    for (int i = 0; i < 256; i++) model[i] = 32'h0;
    model[253] = 32'h7777_5533;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.i_addr         = 10'((i * 29 + 4) * 4 + (i % 4));
      bus.i_data         = $urandom;
      bus.i_write_enable = 2'b11;
      model[(i * 29 + 4)] = bus.i_data;
      edge_step();
    end
    @(negedge clk);
    bus.i_write_enable = 2'b00;
    for (int i = 0; i < 8; i++) begin
      bus.i_addr_debug = 8'(i * 29 + 4);
      bus.i_addr       = 10'((i * 29 + 4) * 4);
      chk("model_debug", model[i * 29 + 4], 1'b1);
      chk("model_read", model[i * 29 + 4], 1'b0);
    end
    bus.i_addr_debug = 8'd253;
    chk("neighbour_intact", 32'h7777_5533, 1'b1);

    // Async reset pulsed between edges while a write is pending.
    bus.i_addr         = 10'd1013;
    bus.i_data         = 32'h1234_5678;
    bus.i_write_enable = 2'b11;
    bus.i_read_enable  = 2'b11;
    #1;
    rst = 1'b0;
    chk("rst_o_data_now", 32'h0, 1'b0);
    chk("rst_debug_now", 32'h0, 1'b1);
    edge_step();
    chk("rst_write_dropped", 32'h0, 1'b0);
    bus.i_addr_debug = 8'd4;
    chk("rst_other_word", 32'h0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    bus.i_addr_debug = 8'd253;
    chk("post_rst_read", 32'h0, 1'b0);
    edge_step();
    chk("post_rst_write", 32'h1234_5678, 1'b0);
    chk("post_rst_debug", 32'h1234_5678, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end
endmodule
